// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: registered N:1 multiplexer with valid/ready handshaking on every
// input channel and on the output. One output register holds out_data, out_chan and
// out_valid. A new word is accepted whenever the register is empty or is being drained
// in the same cycle, so throughput is one word per cycle.
//
// Grant policy:
//   explicit     - sel picks the channel; sel >= N grants nothing.
//   round-robin  - first valid channel searching upward from rr_ptr+1 (mod N).
// The round-robin policy is compiled in only when the macro MUX_RR_EN is defined.
// Without it, mode is ignored and the block is always in explicit mode. The port list
// is the same in both builds.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data           N channels of WIDTH bits; channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready per-channel handshake; in_ready is one-hot or zero
//   sel, mode         explicit channel select, policy select (1 = round-robin)
//   out_data/out_chan registered word and the channel it came from
//   out_valid/out_ready output handshake
module mux_n_to_1_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    logic            can_load;
    logic            ex_vld;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic            xfer;

    // Register is free if empty or being drained this cycle.
    assign can_load = !out_valid_q || out_ready;

    assign ex_vld = 32'(sel) < N;

`ifdef MUX_RR_EN
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] rr_cand;

    // Scan rr_ptr+1 .. rr_ptr+N (mod N); the first valid channel wins, so the
    // previously granted channel has the lowest priority.
    always_comb begin
        rr_vld  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            rr_cand = SELW'((32'(rr_ptr_q) + k) % N);
            if (!rr_vld && in_valid[rr_cand]) begin
                rr_vld = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    assign grant_vld = mode ? rr_vld : ex_vld;
    assign grant_idx = mode ? rr_idx : sel;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && mode) begin
            rr_ptr_d = grant_idx;
        end
    end

    // Reset to N-1 so that channel 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SELW'(N - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    assign grant_vld = ex_vld;
    assign grant_idx = sel;
`endif

    // In explicit mode ready does not look at in_valid.
    always_comb begin
        in_ready = '0;
        if (grant_vld) begin
            in_ready[grant_idx] = can_load;
        end
    end

    assign xfer = grant_vld && in_valid[grant_idx] && can_load;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(grant_idx) * WIDTH +: WIDTH];
            out_chan_d  = grant_idx;
        end else if (out_ready) begin
            // Drained with nothing to replace it; data and chan keep their values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/mux_n_to_1_reg.md
# mux_n_to_1_reg

Parametrised, registered N-input, WIDTH-bit multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the combinational 2:1 datapath muxes. It is used wherever several producers (writeback sources, forwarding paths, memory return channels) compete for one consumer and the datapath needs a pipeline register. Selection is either by an explicit select input or, when compiled in, by round-robin arbitration. Each accepted word appears on the output one cycle later, tagged with its source channel.

## Interface
- WIDTH, 32: data width per channel.
- N, 4: number of input channels, 2..16.
- SELW, $clog2(N): width of select and channel tag.

- clk  in  1: single clock; all state updates on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_data  in  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N: per-channel valid.
- in_ready  out  N: per-channel ready; at most one bit high per cycle (one-hot or zero).
- sel  in  SELW: channel to pass in explicit mode.
- mode  in  1: 0 = explicit select, 1 = round-robin (MUX_RR_EN only).
- out_data  out  WIDTH: registered output word.
- out_valid  out  1: out_data/out_chan hold a word.
- out_ready  in  1: consumer accepts the word.
- out_chan  out  SELW: source channel of out_data.

## Operation
- Storage is one output register: out_data, out_chan and out_valid.
- can_load = !out_valid || out_ready. This is combinational and gives full throughput, one word per cycle.
- Grant (combinational):
  - Explicit mode: g = sel when sel < N. If sel >= N, there is no grant.
  - Round-robin mode: g = the first channel with in_valid set, searching upward from rr_ptr+1 modulo N. If no channel is valid, there is no grant.
- in_ready[g] = can_load when a grant exists. All other in_ready bits are 0. in_ready never depends on in_valid[g] in explicit mode.
- A transfer occurs when in_valid[g] && in_ready[g]. On a transfer:
  - out_data <= channel g data.
  - out_chan <= g.
  - out_valid <= 1.
  - rr_ptr <= g (round-robin mode only).
- When out_valid && out_ready and there is no transfer in the same cycle, out_valid <= 0. out_data and out_chan hold their values.
- When out_valid && !out_ready, the output register is held and every in_ready bit is 0.
- Changes to mode or sel while out_valid is high do not disturb the stored word. They affect only the next grant.
- rr_ptr is not updated in explicit mode. Switching to round-robin resumes from the last round-robin grant.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - out_valid=0, out_data=0, out_chan=0.
  - rr_ptr=N-1, so channel 0 has first priority.
  - in_ready follows combinationally: all zeros in round-robin mode, and in_ready[sel]=1 in explicit mode after reset deassertion.
- Latency: a word accepted at edge k is visible on out_data at edge k. It is presented to the consumer from cycle k to k+1 onward.
- Simultaneous pop and push in one cycle: the register reloads, out_valid stays 1, and there is no bubble.
- Reset asserted mid-transfer: the word held in the register is discarded, with no partial output.
- Round-robin wrap: the search runs N-1, then 0. With all channels continuously valid, grants cycle 0,1,…,N-1,0.
- Data and valid must stay stable while ready is low. This applies to both the input and output interfaces (AXI-style rule).

## Configuration
- MUX_RR_EN defined:
  - The round-robin grant logic and rr_ptr are compiled in.
  - mode selects the grant policy.
- MUX_RR_EN undefined:
  - The round-robin logic is removed and the mode input is ignored.
  - The block always behaves as in explicit mode.
  - The port list is unchanged.

## Test plan
- Reset and explicit pass-through: reset with N=4, sel=2; in_valid[2]=1 with data 0xA5A5_0002; out_ready=1.
  - Required: out_data=0xA5A5_0002 and out_chan=2 one cycle later.
  - Required: in_ready=4'b0100.
- Backpressure: out_ready=0 with one word stored; present new data on channel 1.
  - Required: all in_ready bits 0 and out_data unchanged for 5 cycles.
  - Required: after out_ready=1, the channel-1 word appears the next cycle.
- Streaming: sel=3 with 8 back-to-back words 0..7; out_ready=1 constant.
  - Required: 8 outputs on consecutive cycles, in order, with no bubbles.
- Out-of-range sel: N=3, sel=3, all in_valid=1.
  - Required: in_ready=0 and out_valid stays 0.
- Round-robin fairness (MUX_RR_EN): mode=1, all 4 in_valid=1, out_ready=1 for 8 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1,2,3.
  - Then with only channels 1 and 3 valid, required: alternation 1,3,1,3.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Required: out_valid=0, out_data=0 immediately (asynchronous).
  - Required: the next round-robin grant goes to channel 0.
